jk_excitation_driver: RTL and testbench

- Drives the J/K inputs of an external WIDTH-bit bank of JK flip-flops, inverting the flip-flop's characteristic function: given a requested next state, it computes per-bit J/K from the bank's current Q.
- Target words enter through a valid/ready FIFO. Each word is applied for one cycle, and the bank's response is checked on the following cycle.
- Sits between control logic and the JK register bank. It reports per-word done or mismatch and keeps a saturating error count.

---
 rtl/jk_excitation_driver_if.sv | 11 +
 rtl/jk_excitation_driver.sv | 111 +++++++++++
 tb/tb_jk_excitation_driver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_driver_if.sv
// Target-word stream into the JK excitation driver: valid/ready handshake plus data.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/jk_excitation_driver.sv
// Queues target words and drives J/K so an external JK bank reaches each one, then checks Q.
// Pop on entry to DRIVE, result pulses 3 edges after push; in_ready drops while the FIFO is full.
module jk_excitation_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  jk_excitation_driver_if.slave  in_if,
  input  logic [WIDTH-1:0]       q_fb,
  output logic [WIDTH-1:0]       jk_j,
  output logic [WIDTH-1:0]       jk_k,
  output logic                   busy,
  output logic                   done,
  output logic                   mismatch,
  output logic [7:0]             err_count,
  input  logic                   err_clr,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] target_q;
  logic             done_q, mismatch_q;
  logic [7:0]       err_q, err_d;
  logic             push, pop, match;

  // in_ready is held low while reset is asserted so nothing is accepted during reset
  assign in_if.in_ready = reset && (count_q != FULL);
  assign push           = in_if.in_valid && in_if.in_ready;
  assign pop            = (state_d == DRIVE);
  assign match          = (q_fb == target_q);

  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign done       = done_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      target_q   <= '0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= (state_q == CHECK) && match;
      mismatch_q <= (state_q == CHECK) && !match;
      err_q      <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        target_q <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = DRIVE;
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = (count_q != '0) ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only DRIVE excites the bank; set where the target is 1, reset where it is 0, never toggle
  always_comb begin
    jk_j = '0;
    jk_k = '0;
    if (state_q == DRIVE) begin
      jk_j = target_q & ~q_fb;
      jk_k = ~target_q & q_fb;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Clear wins over a same-cycle mismatch
  always_comb begin
    err_d = err_q;
    if (err_clr)
      err_d = '0;
    else if ((state_q == CHECK) && !match && (err_q != 8'hFF))
      err_d = err_q + 8'd1;
  end
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboarded bench for jk_excitation_driver with a behavioural JK bank on the shared clock.
module tb_jk_excitation_driver;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] q_fb;
  logic [7:0] jk_j, jk_k;
  logic       busy, done, mismatch, err_clr;
  logic [7:0] err_count;
  logic [2:0] fifo_count;

  jk_excitation_driver_if #(.WIDTH(8)) in_if ();

  jk_excitation_driver #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (in_if),
    .q_fb       (q_fb),
    .jk_j       (jk_j),
    .jk_k       (jk_k),
    .busy       (busy),
    .done       (done),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .err_clr    (err_clr),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // JK bank: Q+ = J&~Q | ~K&Q, optional stuck-at-0 bits, optional preload
  logic [7:0] bank_q = 8'h00;
  logic [7:0] stuck_mask = 8'h00;
  logic       bank_load = 1'b0;
  logic [7:0] bank_load_val = 8'h00;
  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_load_val & ~stuck_mask;
    else           bank_q <= ((jk_j & ~bank_q) | (~jk_k & bank_q)) & ~stuck_mask;
  end
  assign q_fb = bank_q;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  logic [8:0] sb_q [$];
  int pulse_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Result monitor: each pulse must match the oldest outstanding word
  always @(negedge clk) begin
    if (done || mismatch) begin
      logic [8:0] e;
      n_pulse++;
      pulse_cyc.push_back(cyc);
      chk("pulse_excl", {31'd0, done & mismatch}, 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_kind", {31'd0, done}, {31'd0, e[8]});
        chk("pulse_q", {24'd0, q_fb}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] d, output int waited);
    logic [7:0] res;
    waited = 0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = d;
    while (!in_if.in_ready && waited < 200) begin
      tick();
      waited++;
    end
    chk("push_accept", {31'd0, in_if.in_ready}, 1);
    res = d & ~stuck_mask;
    sb_q.push_back({(res == d), res});
    tick();
    in_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    chk("drain", {31'd0, (sb_q.size() == 0) && !busy}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int idle_seen;
    int base;
    logic [7:0] stream [4];
    stream[0] = 8'h00; stream[1] = 8'hFF; stream[2] = 8'hAA; stream[3] = 8'h55;

    // 1: reset with a word offered
    reset = 1'b0; err_clr = 1'b0;
    in_if.in_valid = 1'b1; in_if.in_data = 8'h77;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_if.in_ready}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_mismatch", {31'd0, mismatch}, 0);
    chk("rst_jk", {16'd0, jk_j, jk_k}, 0);
    chk("rst_err", {24'd0, err_count}, 0);
    chk("rst_fifo", {29'd0, fifo_count}, 0);
    reset = 1'b1; in_if.in_valid = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_if.in_ready}, 1);
    tick();
    chk("rel_fifo", {29'd0, fifo_count}, 0);

    // 2: single word from Q=F0 to 3C
    bank_load = 1'b1; bank_load_val = 8'hF0;
    tick();
    bank_load = 1'b0;
    push_word(8'h3C, w);
    chk("single_jk_idle", {16'd0, jk_j, jk_k}, 0);
    tick();
    chk("single_drive_j", {24'd0, jk_j}, 32'h0C);
    chk("single_drive_k", {24'd0, jk_k}, 32'hC0);
    tick();
    chk("single_check_q", {24'd0, q_fb}, 32'h3C);
    chk("single_check_jk", {16'd0, jk_j, jk_k}, 0);
    tick();
    chk("single_done", {31'd0, done}, 1);
    chk("single_nomis", {31'd0, mismatch}, 0);
    tick();
    chk("single_done_end", {31'd0, done}, 0);
    drain();

    // 3: fill the FIFO, hold an extra word while full
    base = 0;
    while (fifo_count != 3'd4 && base < 16) begin
      push_word(8'h11 * base[7:0] + 8'h01, w);
      base++;
    end
    chk("full_count", {29'd0, fifo_count}, 4);
    chk("full_ready", {31'd0, in_if.in_ready}, 0);
    push_word(8'hE7, w);
    chk("full_held", {31'd0, (w >= 1)}, 1);
    drain();

    // 4: back-to-back stream, no IDLE gaps
    pulse_cyc.delete();
    idle_seen = 0;
    for (int i = 0; i < 4; i++) begin
      push_word(stream[i], w);
      if (!busy) idle_seen++;
    end
    base = 0;
    while (pulse_cyc.size() < 4 && base < 50) begin
      if (!busy && pulse_cyc.size() < 3) idle_seen++;
      tick();
      base++;
    end
    chk("stream_pulses", pulse_cyc.size(), 4);
    chk("stream_no_idle", idle_seen, 0);
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk("stream_spacing", pulse_cyc[i] - pulse_cyc[i-1], 2);
    drain();

    // 5: bit0 stuck at 0
    stuck_mask = 8'h01;
    tick();
    for (int i = 0; i < 3; i++) push_word(8'h01, w);
    drain();
    chk("fault_err3", {24'd0, err_count}, 3);
    push_word(8'h01, w);
    tick();
    chk("fault_drive_j", {24'd0, jk_j}, 32'h01);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("fault_clr_mis", {31'd0, mismatch}, 1);
    chk("fault_clr_err", {24'd0, err_count}, 0);
    drain();

    // 6: saturation, then reset during DRIVE
    for (int i = 0; i < 260; i++) push_word(8'h01, w);
    drain();
    chk("sat_err", {24'd0, err_count}, 255);
    stuck_mask = 8'h00;
    push_word(8'h5A, w);
    tick();
    chk("midrst_drive_j", {24'd0, jk_j}, 32'h5A);
    reset = 1'b0;
    sb_q.delete();
    base = n_pulse;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, in_if.in_ready}, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_no_pulse", n_pulse, base);
    chk("midrst_fifo", {29'd0, fifo_count}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_err", {24'd0, err_count}, 0);
    chk("midrst_jk", {16'd0, jk_j, jk_k}, 0);
    chk("midrst_flags", {30'd0, done, mismatch}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
